// File: rtl/pwm_capture.sv
// rtl/pwm_capture.sv - measures an incoming PWM waveform in clk cycles
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   en         synchronous capture enable
//   pwm_in     asynchronous PWM input
//   cap_period rising-to-rising count minus 1
//   cap_cmp    high-time count
//   valid      one-cycle strobe, cap_period/cap_cmp updated with it
//   timeout    no edge for TIMEOUT cycles, sticky until next valid
//   level      synchronized pwm_in
module pwm_capture #(
  parameter int               WIDTH   = 16,
  parameter logic [WIDTH-1:0] TIMEOUT = 16'hFFFF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             pwm_in,
  output logic [WIDTH-1:0] cap_period,
  output logic [WIDTH-1:0] cap_cmp,
  output logic             valid,
  output logic             timeout,
  output logic             level
);

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  state_t           state_q, state_d;
  logic             s1, s2, s3;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] per_d, cmp_d;
  logic             valid_d, timeout_d;
  logic             rise, fall;
  logic             cnt_sat;
  logic [WIDTH-1:0] cnt_inc;

  assign rise    = s2 & ~s3;
  assign fall    = ~s2 & s3;
  assign level   = s2;
  assign cnt_sat = (cnt_q == TIMEOUT);
  assign cnt_inc = cnt_sat ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    per_d     = cap_period;
    cmp_d     = cap_cmp;
    valid_d   = 1'b0;
    timeout_d = timeout;
    if (!en) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        // IDLE also counts so a pin that never toggles after enable is reported.
        IDLE: begin
          if (rise) begin
            state_d = HIGH;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
            if (cnt_sat) timeout_d = 1'b1;
          end
        end
        HIGH: begin
          if (fall) begin
            // cnt lags the high cycle count by one at the fall; saturate rather than wrap.
            hi_d    = (cnt_q == {WIDTH{1'b1}}) ? cnt_q : cnt_q + 1'b1;
            cnt_d   = cnt_inc;
            state_d = LOW;
          end else if (cnt_sat) begin
            timeout_d = 1'b1;
            state_d   = IDLE;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        LOW: begin
          if (rise) begin
            per_d     = cnt_q;
            cmp_d     = hi_q;
            valid_d   = 1'b1;
            timeout_d = 1'b0;
            cnt_d     = '0;
            state_d   = HIGH;
          end else if (cnt_sat) begin
            timeout_d = 1'b1;
            state_d   = IDLE;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1         <= 1'b0;
      s2         <= 1'b0;
      s3         <= 1'b0;
      state_q    <= IDLE;
      cnt_q      <= '0;
      hi_q       <= '0;
      cap_period <= '0;
      cap_cmp    <= '0;
      valid      <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      s1         <= pwm_in;
      s2         <= s1;
      s3         <= s2;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      hi_q       <= hi_d;
      cap_period <= per_d;
      cap_cmp    <= cmp_d;
      valid      <= valid_d;
      timeout    <= timeout_d;
    end
  end

endmodule
